decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: INSTR_W, 16, instruction width in bits.
REQ-002 Parameter: OPC_W, 4, opcode width; opcode is instr[INSTR_W-1 -: OPC_W].
REQ-003 Parameter: REG_AW, 4, register address width; rd/rs/rt are the next three REG_AW fields below opcode, MSB first.
REQ-004 Parameter: IMM_W, 8, immediate width; imm is instr[IMM_W-1:0]; nzp is the top 3 bits of the rd field.
REQ-005 Parameter: CNT_W, 16, decoded-instruction counter width.
REQ-006 Port: clk  in  1  clock, all state on rising edge.
REQ-007 Port: reset  in  1  reset, synchronous, active-high.
REQ-008 Port: flush  in  1  discards buffered entries and leaves HALT/TRAP.
REQ-009 Port: in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-010 Port: in_instr  in  INSTR_W  raw instruction.
REQ-011 Port: out_valid / out_ready  out / in  1 / 1  decoded-bundle handshake.
REQ-012 Port: rd_addr, rs_addr, rt_addr  out  REG_AW each; nzp  out  3; imm  out  IMM_W.
REQ-013 Port: reg_we, mem_re, mem_we, nzp_we, alu_out_mux, next_pc_mux, ret  out  1 each; reg_in_mux, alu_ctrl  out  2 each.
REQ-014 Port: illegal  out  1  bundle carries an undefined opcode.
REQ-015 Port: state  out  2  RUN=0, HALT=1, TRAP=2.
REQ-016 Port: dec_count  out  CNT_W  bundles accepted downstream since reset/flush.

Function
REQ-017 Opcode map: 0 NOP; 1 BR (nzp, imm, next_pc_mux); 2 CMP (rs, rt, alu_ctrl=01, alu_out_mux, nzp_we); 3/4/5/6 ADD/SUB/MUL/DIV (rd, rs, rt, alu_ctrl=00/01/10/11, reg_we, reg_in_mux=00); 7 LDR (rd, rs, mem_re, reg_we, reg_in_mux=01); 8 STR (rs, rt, mem_we); 9 CONST (rd, imm, reg_we, reg_in_mux=10); 15 RET (ret); 10-14 illegal.
REQ-018 Fields unused by an opcode are output as 0; control bits not listed are 0; illegal bundles are all-zero except illegal=1.
REQ-019 Output stage is a 2-entry skid buffer: main register plus skid register; in_ready is registered and depends only on internal state.
REQ-020 Latency: a bundle accepted at edge N is on the outputs with out_valid=1 after edge N, when the buffer was empty.
REQ-021 Bundle transfers when out_valid && out_ready; outputs hold stable while out_valid && !out_ready.
REQ-022 in_ready=1 iff state==RUN and the skid register is empty; full throughput at out_ready=1, no bubbles.
REQ-023 Simultaneous accept and drain with one entry held: the new bundle replaces the main entry; occupancy unchanged.
REQ-024 Accepting RET moves RUN->HALT; in_ready drops the following cycle; buffered bundles (including RET) still drain.
REQ-025 HALT and TRAP exit only via flush or reset.
REQ-026 flush: both entries invalidated, out_valid=0 and state=RUN next cycle, dec_count=0; any same-cycle input is discarded; flush takes priority over every other event.
REQ-027 dec_count increments per output transfer and wraps at 2^CNT_W-1 -> 0.

Reset
REQ-028 reset: state=RUN, both entries empty, out_valid=0, in_ready=1, all bundle outputs 0, dec_count=0.
REQ-029 reset mid-transfer discards all in-flight bundles; no partial output survives.

Configuration
REQ-030 Macro DECODE_ILLEGAL_TRAP_EN defined: accepting an illegal opcode moves RUN->TRAP (in_ready drops like HALT); the illegal bundle still drains.
REQ-031 Macro undefined: illegal opcodes are flagged (illegal=1) but decode as NOP and state stays RUN; TRAP is unreachable.

Structure
REQ-032 Shared package holds opcode constants, alu_ctrl and reg_in_mux encodings, state enum and the decoded-bundle struct.
REQ-033 Sub-module decode_comb: pure combinational instr->bundle decode; decode_stage holds handshake, skid buffer, FSM and counter.

Verification
REQ-034 out_ready=1, stream 0x3123, 0x9A05, 0x2012 -> ADD rd=1 rs=2 rt=3; CONST rd=A imm=05 reg_in_mux=10; CMP nzp_we=1; one per cycle; dec_count=3.
REQ-035 out_ready=0 for 3 cycles over 3 inputs -> two held, in_ready=0 after second accept, no loss, order preserved on release.
REQ-036 RET 0xF000 then ADD offered -> state=HALT, ADD not accepted; RET drains with ret=1; flush -> RUN, in_ready=1.
REQ-037 0xA000 with DECODE_ILLEGAL_TRAP_EN -> illegal=1, state=TRAP; without it -> illegal=1, state=RUN, next instruction accepted.
REQ-038 CNT_W=4, 17 transfers -> dec_count=1; reset with two held entries -> out_valid=0, dec_count=0 next cycle.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode map, control encodings,
// run-state enum and the decoded-bundle struct.
package decode_stage_pkg;

  // Bundle field widths; decode_stage's REG_AW/IMM_W parameters must match these.
  localparam int REG_AW_P = 4;
  localparam int IMM_W_P  = 8;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_BR    = 4'd1;
  localparam logic [3:0] OP_CMP   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_LDR   = 4'd7;
  localparam logic [3:0] OP_STR   = 4'd8;
  localparam logic [3:0] OP_CONST = 4'd9;
  localparam logic [3:0] OP_RET   = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  localparam logic [1:0] RIN_ALU   = 2'b00;
  localparam logic [1:0] RIN_MEM   = 2'b01;
  localparam logic [1:0] RIN_CONST = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  typedef struct packed {
    logic                illegal;
    logic [1:0]          alu_ctrl;
    logic [1:0]          reg_in_mux;
    logic                ret;
    logic                next_pc_mux;
    logic                alu_out_mux;
    logic                nzp_we;
    logic                mem_we;
    logic                mem_re;
    logic                reg_we;
    logic [IMM_W_P-1:0]  imm;
    logic [2:0]          nzp;
    logic [REG_AW_P-1:0] rt;
    logic [REG_AW_P-1:0] rs;
    logic [REG_AW_P-1:0] rd;
  } bundle_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction decoder: raw instruction -> decoded bundle.
// Fields an opcode does not use are zero; undefined opcodes yield only illegal=1.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = REG_AW_P,
  parameter int IMM_W   = IMM_W_P
) (
  input  logic [INSTR_W-1:0] i_instr,
  output bundle_t            o_bundle
);

  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [IMM_W-1:0]  w_imm;

  assign w_opc = i_instr[INSTR_W-1 -: OPC_W];
  assign w_rd  = i_instr[INSTR_W-OPC_W-1 -: REG_AW];
  assign w_rs  = i_instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign w_rt  = i_instr[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign w_imm = i_instr[IMM_W-1:0];

  always_comb begin
    // NOTE: every field gets a default before the case, so no path leaves a latch.
    o_bundle = '0;
    case (w_opc)
      OP_NOP: ;
      OP_BR: begin
        o_bundle.nzp         = w_rd[REG_AW-1 -: 3];
        o_bundle.imm         = w_imm;
        o_bundle.next_pc_mux = 1'b1;
      end
      OP_CMP: begin
        o_bundle.rs          = w_rs;
        o_bundle.rt          = w_rt;
        o_bundle.alu_ctrl    = ALU_SUB;
        o_bundle.alu_out_mux = 1'b1;
        o_bundle.nzp_we      = 1'b1;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        o_bundle.rd         = w_rd;
        o_bundle.rs         = w_rs;
        o_bundle.rt         = w_rt;
        // The four arithmetic opcodes are consecutive, in alu_ctrl order.
        o_bundle.alu_ctrl   = 2'(w_opc - OP_ADD);
        o_bundle.reg_we     = 1'b1;
        o_bundle.reg_in_mux = RIN_ALU;
      end
      OP_LDR: begin
        o_bundle.rd         = w_rd;
        o_bundle.rs         = w_rs;
        o_bundle.mem_re     = 1'b1;
        o_bundle.reg_we     = 1'b1;
        o_bundle.reg_in_mux = RIN_MEM;
      end
      OP_STR: begin
        o_bundle.rs     = w_rs;
        o_bundle.rt     = w_rt;
        o_bundle.mem_we = 1'b1;
      end
      OP_CONST: begin
        o_bundle.rd         = w_rd;
        o_bundle.imm        = w_imm;
        o_bundle.reg_we     = 1'b1;
        o_bundle.reg_in_mux = RIN_CONST;
      end
      OP_RET: o_bundle.ret = 1'b1;
      default: o_bundle.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decoder, 2-entry skid buffer, RUN/HALT/TRAP state and transfer counter.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to stop in TRAP on an illegal opcode.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_AW  = REG_AW_P,
  parameter int IMM_W   = IMM_W_P,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  rd_addr,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [REG_AW-1:0]  rt_addr,
  output logic [2:0]         nzp,
  output logic [IMM_W-1:0]   imm,
  output logic               reg_we,
  output logic               mem_re,
  output logic               mem_we,
  output logic               nzp_we,
  output logic               alu_out_mux,
  output logic               next_pc_mux,
  output logic               ret,
  output logic [1:0]         reg_in_mux,
  output logic [1:0]         alu_ctrl,
  output logic               illegal,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   dec_count
);

  bundle_t          w_dec;
  bundle_t          r_main;
  bundle_t          r_skid;
  logic             r_main_v;
  logic             r_skid_v;
  logic             r_in_ready;
  state_e           r_state;
  logic [CNT_W-1:0] r_count;

  logic   w_accept;
  logic   w_drain;
  logic   w_trap_hit;
  logic   w_skid_v_nxt;
  state_e w_state_nxt;

  decode_comb #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .REG_AW  (REG_AW),
    .IMM_W   (IMM_W)
  ) u_decode (
    .i_instr  (in_instr),
    .o_bundle (w_dec)
  );

  assign w_accept = in_valid && r_in_ready;
  assign w_drain  = r_main_v && out_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_trap_hit = w_dec.illegal;
`else
  assign w_trap_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && w_dec.ret)
      w_state_nxt = ST_HALT;
    else if (w_accept && w_trap_hit)
      w_state_nxt = ST_TRAP;

    // The skid slot fills only when a new bundle arrives while main is stuck.
    w_skid_v_nxt = r_skid_v;
    if (w_drain)
      w_skid_v_nxt = 1'b0;
    else if (w_accept && r_main_v)
      w_skid_v_nxt = 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state    <= ST_RUN;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= (w_state_nxt == ST_RUN) && !w_skid_v_nxt;
      if (w_drain)
        r_count <= r_count + 1'b1;

      if (w_drain) begin
        if (r_skid_v) begin
          r_main   <= r_skid;
          r_main_v <= 1'b1;
        end else if (w_accept) begin
          r_main   <= w_dec;
          r_main_v <= 1'b1;
        end else begin
          r_main_v <= 1'b0;
        end
      end else if (!r_main_v && w_accept) begin
        r_main   <= w_dec;
        r_main_v <= 1'b1;
      end
    end
  end

  // NOTE: skid payload has no reset; it is only ever read while r_skid_v is set.
  always_ff @(posedge clk) begin
    if (w_accept && r_main_v && !w_drain)
      r_skid <= w_dec;
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_v;
  assign rd_addr     = r_main.rd;
  assign rs_addr     = r_main.rs;
  assign rt_addr     = r_main.rt;
  assign nzp         = r_main.nzp;
  assign imm         = r_main.imm;
  assign reg_we      = r_main.reg_we;
  assign mem_re      = r_main.mem_re;
  assign mem_we      = r_main.mem_we;
  assign nzp_we      = r_main.nzp_we;
  assign alu_out_mux = r_main.alu_out_mux;
  assign next_pc_mux = r_main.next_pc_mux;
  assign ret         = r_main.ret;
  assign reg_in_mux  = r_main.reg_in_mux;
  assign alu_ctrl    = r_main.alu_ctrl;
  assign illegal     = r_main.illegal;
  assign state       = r_state;
  assign dec_count   = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef logic [34:0] bvec_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_instr;

  logic        in_ready, out_valid, reg_we, mem_re, mem_we, nzp_we;
  logic        alu_out_mux, next_pc_mux, ret, illegal;
  logic [3:0]  rd_addr, rs_addr, rt_addr;
  logic [2:0]  nzp;
  logic [7:0]  imm;
  logic [1:0]  reg_in_mux, alu_ctrl, state;
  logic [15:0] dec_count;

  logic        u4_in_ready, u4_out_valid, u4_reg_we, u4_mem_re, u4_mem_we, u4_nzp_we;
  logic        u4_alu_out_mux, u4_next_pc_mux, u4_ret, u4_illegal;
  logic [3:0]  u4_rd_addr, u4_rs_addr, u4_rt_addr;
  logic [2:0]  u4_nzp;
  logic [7:0]  u4_imm;
  logic [1:0]  u4_reg_in_mux, u4_alu_ctrl, u4_state;
  logic [3:0]  u4_dec_count;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr), .nzp(nzp), .imm(imm),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .nzp_we(nzp_we),
    .alu_out_mux(alu_out_mux), .next_pc_mux(next_pc_mux), .ret(ret),
    .reg_in_mux(reg_in_mux), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .state(state), .dec_count(dec_count)
  );

  decode_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(u4_in_ready), .in_instr(in_instr),
    .out_valid(u4_out_valid), .out_ready(out_ready),
    .rd_addr(u4_rd_addr), .rs_addr(u4_rs_addr), .rt_addr(u4_rt_addr), .nzp(u4_nzp), .imm(u4_imm),
    .reg_we(u4_reg_we), .mem_re(u4_mem_re), .mem_we(u4_mem_we), .nzp_we(u4_nzp_we),
    .alu_out_mux(u4_alu_out_mux), .next_pc_mux(u4_next_pc_mux), .ret(u4_ret),
    .reg_in_mux(u4_reg_in_mux), .alu_ctrl(u4_alu_ctrl), .illegal(u4_illegal),
    .state(u4_state), .dec_count(u4_dec_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO of expected bundles (depth 2), run state, transfer count.
  bvec_t       mq[$];
  int          m_state = 0;
  int unsigned m_count = 0;
  bit          m_live  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Opcode table from the instruction-set description, as field-usage flags.
  function automatic bvec_t model_decode(input logic [15:0] ins);
    logic [3:0] op = ins[15:12];
    bit u_rd = 0, u_rs = 0, u_rt = 0, u_imm = 0, u_nzp = 0;
    bit we = 0, mre = 0, mwe = 0, nwe = 0, aom = 0, npc = 0, rt_f = 0, ill = 0;
    logic [1:0] rim = 2'd0, alu = 2'd0;
    case (op)
      4'd0: ;
      4'd1: begin u_nzp = 1; u_imm = 1; npc = 1; end
      4'd2: begin u_rs = 1; u_rt = 1; alu = 2'd1; aom = 1; nwe = 1; end
      4'd3, 4'd4, 4'd5, 4'd6: begin
        u_rd = 1; u_rs = 1; u_rt = 1; we = 1;
        alu = (op == 4'd3) ? 2'd0 : (op == 4'd4) ? 2'd1 : (op == 4'd5) ? 2'd2 : 2'd3;
      end
      4'd7: begin u_rd = 1; u_rs = 1; mre = 1; we = 1; rim = 2'd1; end
      4'd8: begin u_rs = 1; u_rt = 1; mwe = 1; end
      4'd9: begin u_rd = 1; u_imm = 1; we = 1; rim = 2'd2; end
      4'd15: rt_f = 1;
      default: ill = 1;
    endcase
    return {ill, alu, rim, rt_f, npc, aom, nwe, mwe, mre, we,
            u_imm ? ins[7:0] : 8'h00, u_nzp ? ins[11:9] : 3'h0,
            u_rt ? ins[3:0] : 4'h0, u_rs ? ins[7:4] : 4'h0, u_rd ? ins[11:8] : 4'h0};
  endfunction

  function automatic bvec_t pack_dut();
    return {illegal, alu_ctrl, reg_in_mux, ret, next_pc_mux, alu_out_mux, nzp_we,
            mem_we, mem_re, reg_we, imm, nzp, rt_addr, rs_addr, rd_addr};
  endfunction

  function automatic bvec_t pack_u4();
    return {u4_illegal, u4_alu_ctrl, u4_reg_in_mux, u4_ret, u4_next_pc_mux, u4_alu_out_mux,
            u4_nzp_we, u4_mem_we, u4_mem_re, u4_reg_we, u4_imm, u4_nzp, u4_rt_addr,
            u4_rs_addr, u4_rd_addr};
  endfunction

  task automatic compare_model();
    if (m_live) begin
      check("out_valid", out_valid, mq.size() > 0);
      check("in_ready", in_ready, (m_state == 0) && (mq.size() < 2));
      check("state", state, m_state);
      check("dec_count", dec_count, m_count[15:0]);
      check("dec_count_w4", u4_dec_count, m_count[3:0]);
      if (mq.size() > 0) begin
        check("bundle", pack_dut(), mq[0]);
        check("bundle_w4", pack_u4(), mq[0]);
      end
    end
  endtask

  task automatic model_edge(input bit rst_i, input bit fl_i, input bit iv_i,
                            input logic [15:0] ins_i, input bit ordy_i);
    bit acc;
    if (rst_i || fl_i) begin
      mq.delete();
      m_state = 0;
      m_count = 0;
      m_live  = 1'b1;
    end else if (m_live) begin
      acc = iv_i && (m_state == 0) && (mq.size() < 2);
      if (mq.size() > 0 && ordy_i) begin
        void'(mq.pop_front());
        m_count++;
      end
      if (acc) begin
        mq.push_back(model_decode(ins_i));
        if (ins_i[15:12] == 4'hF)
          m_state = 1;
        else if (TRAP_EN && ins_i[15:12] >= 4'd10)
          m_state = 2;
      end
    end
  endtask

  // Called just after a falling edge: check, drive, advance model, move to next falling edge.
  task automatic step(input bit rst_i, input bit fl_i, input bit iv_i,
                      input logic [15:0] ins_i, input bit ordy_i);
    compare_model();
    reset     = rst_i;
    flush     = fl_i;
    in_valid  = iv_i;
    in_instr  = ins_i;
    out_ready = ordy_i;
    model_edge(rst_i, fl_i, iv_i, ins_i, ordy_i);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 16'h0000, 0);

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", state, 0);
    check("rst_dec_count", dec_count, 0);
    check("rst_bundle", pack_dut(), 0);

    // Back-to-back stream at full throughput.
    step(0, 0, 1, 16'h3123, 1);
    check("add_rd", rd_addr, 4'h1);
    check("add_rs", rs_addr, 4'h2);
    check("add_rt", rt_addr, 4'h3);
    check("add_ctl", {reg_we, alu_ctrl, reg_in_mux}, 5'b1_00_00);
    step(0, 0, 1, 16'h9A05, 1);
    check("const_rd", rd_addr, 4'hA);
    check("const_imm", imm, 8'h05);
    check("const_mux", reg_in_mux, 2'b10);
    step(0, 0, 1, 16'h2012, 1);
    check("cmp_ctl", {nzp_we, alu_out_mux, alu_ctrl, reg_we}, 5'b1_1_01_0);
    check("cmp_regs", {rd_addr, rs_addr, rt_addr}, 12'h012);
    step(0, 0, 0, 16'h0000, 1);
    check("stream_count", dec_count, 16'd3);
    check("stream_empty", out_valid, 0);

    // Downstream stall over three offers: two held, third refused, order kept.
    step(0, 0, 1, 16'h3456, 0);
    step(0, 0, 1, 16'h4789, 0);
    check("stall_in_ready", in_ready, 0);
    check("stall_head", rd_addr, 4'h4);
    step(0, 0, 1, 16'h5ABC, 0);
    check("stall_hold", {out_valid, rd_addr}, 5'h14);
    step(0, 0, 1, 16'h5ABC, 1);
    check("release_2nd", {rd_addr, alu_ctrl}, 6'b0111_01);
    check("release_ready", in_ready, 1);
    step(0, 0, 1, 16'h5ABC, 1);
    check("release_3rd", {rd_addr, alu_ctrl}, 6'b1010_10);
    step(0, 0, 0, 16'h0000, 1);
    check("release_count", dec_count, 16'd6);

    // RET halts intake but still drains; flush recovers.
    step(0, 0, 1, 16'hF000, 0);
    check("ret_state", state, 2'd1);
    check("ret_in_ready", in_ready, 0);
    check("ret_bit", ret, 1);
    step(0, 0, 1, 16'h3123, 0);
    step(0, 0, 1, 16'h3123, 1);
    check("ret_drained", out_valid, 0);
    check("halt_sticky", state, 2'd1);
    step(0, 1, 1, 16'h3123, 1);
    check("flush_state", state, 2'd0);
    check("flush_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    check("flush_count", dec_count, 16'd0);

    // Illegal opcode.
    step(0, 0, 1, 16'hA000, 1);
    check("ill_bundle", {out_valid, pack_dut()}, {1'b1, 35'h4_0000_0000});
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("ill_state", state, 2'd2);
    step(0, 0, 1, 16'h3123, 1);
    check("trap_no_accept", out_valid, 0);
`else
    check("ill_state", state, 2'd0);
    step(0, 0, 1, 16'h3123, 1);
    check("ill_next_accept", {out_valid, rd_addr}, 5'h11);
`endif
    step(0, 1, 0, 16'h0000, 1);

    // Counter wrap on the 4-bit instance, then reset with two held entries.
    for (int i = 0; i < 18; i++) step(0, 0, 1, 16'h3123, 1);
    check("wrap_w4", u4_dec_count, 4'd1);
    check("wrap_w16", dec_count, 16'd17);
    step(0, 0, 1, 16'h4789, 0);
    step(0, 0, 1, 16'h5ABC, 0);
    check("held_two", {out_valid, in_ready}, 2'b10);
    step(1, 0, 1, 16'h3123, 0);
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_count", dec_count, 16'd0);
    check("mid_reset_bundle", pack_dut(), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      r = $urandom_range(0, 999);
      step(r < 3, (r >= 3) && (r < 50), $urandom_range(0, 9) < 7,
           16'($urandom), $urandom_range(0, 3) != 0);
    end
    compare_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
